// File: rtl/sap_clk_pkg.sv
// rtl/sap_clk_pkg.sv - shared state encoding and defaults for the SAP-1 clock controller
package sap_clk_pkg;

  localparam int DIV_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } sap_state_e;

endpackage

// File: rtl/sap_clk_divider.sv
// rtl/sap_clk_divider.sv - programmable run-mode divider with >= terminal count and wrap
module sap_clk_divider
  import sap_clk_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] term;

  // Terminal value is eff-1 where 0 and 1 both mean "every cycle".
  always_comb begin
    term = '0;
    if (div_value != '0) term = div_value - ONE;
  end

  // Using >= lets a shrinking div_value end the current period at once.
  assign tick = enable & ~clear & (count >= term);

  // Count up while enabled, wrap on terminal count, hold at zero when cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/sap_clock_ctrl.sv
// rtl/sap_clock_ctrl.sv - SAP-1 clock enable generator: run divider, single step, halt freeze
module sap_clock_ctrl
  import sap_clk_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_mode,
  input  logic                 step_pulse,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 hlt,
  output logic                 cpu_ce,
  output logic                 cpu_clk_led,
  output logic                 halted,
  output logic [1:0]           mode_state
);

  sap_state_e state;
  logic       step_q;
  logic       step_rise;
  logic       div_clear;
  logic       div_enable;
  logic       div_tick;

  assign step_rise  = step_pulse & ~step_q;
  assign div_enable = (state == ST_RUN);
  // Any cycle that leaves RUN (or is not in RUN) restarts the period from zero.
  assign div_clear  = (state != ST_RUN) | hlt | ~run_mode;
  assign mode_state = state;

  sap_clk_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .clear     (div_clear),
    .enable    (div_enable),
    .div_value (div_value),
    .tick      (div_tick)
  );

  // Mode FSM with registered ce, LED toggle and halt flag; hlt beats mode change beats ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STEP;
      step_q      <= 1'b0;
      cpu_ce      <= 1'b0;
      cpu_clk_led <= 1'b0;
      halted      <= 1'b0;
    end else begin
      step_q <= step_pulse;
      cpu_ce <= 1'b0;
      case (state)
        ST_STEP: begin
          if (hlt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (run_mode) begin
            state <= ST_RUN;
          end else if (step_rise) begin
            cpu_ce      <= 1'b1;
            cpu_clk_led <= ~cpu_clk_led;
          end
        end
        ST_RUN: begin
          if (hlt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (!run_mode) begin
            state <= ST_STEP;
          end else if (div_tick) begin
            cpu_ce      <= 1'b1;
            cpu_clk_led <= ~cpu_clk_led;
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_STEP;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// tb/tb_sap_clock_ctrl.sv - self-checking bench for sap_clock_ctrl against a cycle-age model
module tb_sap_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_mode = 1'b0;
  logic        step_pulse = 1'b0;
  logic [23:0] div_value = 24'd4;
  logic        hlt = 1'b0;
  logic        cpu_ce;
  logic        cpu_clk_led;
  logic        halted;
  logic [1:0]  mode_state;

  int n_tests = 0;
  int n_fail  = 0;

  sap_clock_ctrl #(.DIV_WIDTH(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_mode    (run_mode),
    .step_pulse  (step_pulse),
    .div_value   (div_value),
    .hlt         (hlt),
    .cpu_ce      (cpu_ce),
    .cpu_clk_led (cpu_clk_led),
    .halted      (halted),
    .mode_state  (mode_state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 step, 1 run, 2 halt; a run period ends once its age reaches eff.
  int      m_mode = 0;
  bit      m_prev_step = 1'b0;
  longint  m_cyc = 0;
  longint  m_pstart = 0;
  bit      m_ce = 1'b0;
  bit      m_led = 1'b0;
  bit      m_halt;
  bit [1:0] m_ms;
  assign m_halt = (m_mode == 2);
  assign m_ms   = 2'(m_mode);

  always @(posedge clk) begin
    int eff;
    bit rise;
    bit ce;
    ce   = 1'b0;
    rise = step_pulse && !m_prev_step;
    eff  = (div_value == 0) ? 1 : int'(div_value);
    if (rst) begin
      m_mode      = 0;
      m_ce        = 1'b0;
      m_led       = 1'b0;
      m_prev_step = 1'b0;
    end else begin
      if (m_mode != 2 && hlt) m_mode = 2;
      else if (m_mode == 0 && run_mode) begin
        m_mode   = 1;
        m_pstart = m_cyc + 1;
      end else if (m_mode == 1 && !run_mode) m_mode = 0;
      else if (m_mode == 0) ce = rise;
      else if (m_mode == 1) begin
        if (m_cyc - m_pstart + 1 >= longint'(eff)) begin
          ce       = 1'b1;
          m_pstart = m_cyc + 1;
        end
      end
      m_ce        = ce;
      m_led       = m_led ^ ce;
      m_prev_step = step_pulse;
    end
    m_cyc++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_tests++;
    if ({cpu_ce, cpu_clk_led, halted, mode_state} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_state: got ce=%b led=%b halted=%b ms=%b, want all 0", cpu_ce, cpu_clk_led, halted, mode_state);
    end
  endtask

  task automatic test_step();
    int ces = 0;
    int first = -1;
    step_pulse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) step_pulse = 1'b0;
      cyc();
      n_tests++;
      if ({cpu_ce, cpu_clk_led, halted, mode_state} !== {m_ce, m_led, m_halt, m_ms}) begin
        n_fail++;
        $display("FAIL step_model[%0d]: got %b%b%b%b want %b%b%b%b", i, cpu_ce, cpu_clk_led, halted, mode_state, m_ce, m_led, m_halt, m_ms);
      end
      if (cpu_ce) begin
        ces++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (ces !== 1 || first !== 0 || cpu_clk_led !== 1'b1 || mode_state !== 2'b00) begin
      n_fail++;
      $display("FAIL step_held: got ces=%0d first=%0d led=%b ms=%b, want 1 0 1 00", ces, first, cpu_clk_led, mode_state);
    end
  endtask

  task automatic test_run();
    int ces = 0;
    int first = -1;
    bit led0;
    div_value = 24'd4;
    run_mode  = 1'b1;
    cyc();
    led0 = cpu_clk_led;
    n_tests++;
    if (mode_state !== 2'b01 || cpu_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: got ms=%b ce=%b want 01 0", mode_state, cpu_ce);
    end
    for (int k = 1; k <= 40; k++) begin
      cyc();
      n_tests++;
      if ({cpu_ce, cpu_clk_led, halted, mode_state} !== {m_ce, m_led, m_halt, m_ms}) begin
        n_fail++;
        $display("FAIL run_model[%0d]: got %b%b%b%b want %b%b%b%b", k, cpu_ce, cpu_clk_led, halted, mode_state, m_ce, m_led, m_halt, m_ms);
      end
      if (cpu_ce) begin
        ces++;
        if (first < 0) first = k;
        n_tests++;
        if (k % 4 != 0) begin
          n_fail++;
          $display("FAIL run_period: ce at offset %0d, want multiple of 4", k);
        end
      end
    end
    n_tests++;
    if (ces !== 10 || first !== 4 || cpu_clk_led !== led0) begin
      n_fail++;
      $display("FAIL run_count: got ces=%0d first=%0d led=%b want 10 4 %b", ces, first, cpu_clk_led, led0);
    end
  endtask

  task automatic test_div_edges();
    int ces;
    for (int d = 0; d < 2; d++) begin
      div_value = 24'(d);
      ces = 0;
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (cpu_ce) ces++;
      end
      n_tests++;
      if (ces !== 6) begin
        n_fail++;
        $display("FAIL div_every_cycle[%0d]: got %0d ce in 6 cycles want 6", d, ces);
      end
    end
    div_value = 24'd100;
    for (int i = 0; i < 60; i++) cyc();
    div_value = 24'd10;
    cyc();
    n_tests++;
    if (cpu_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL div_shrink: got ce=%b want 1", cpu_ce);
    end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      n_tests++;
      if (cpu_ce !== ((k % 10) == 0) || cpu_ce !== m_ce) begin
        n_fail++;
        $display("FAIL div_after_shrink[%0d]: got ce=%b want %b", k, cpu_ce, (k % 10) == 0);
      end
    end
  endtask

  task automatic test_halt();
    int guard = 0;
    int ces = 0;
    div_value = 24'd3;
    cyc();
    while (!cpu_ce && guard < 10) begin
      cyc();
      guard++;
    end
    n_tests++;
    if (!cpu_ce) begin
      n_fail++;
      $display("FAIL halt_sync: no ce within 10 cycles, want one");
    end
    cyc();
    cyc();
    hlt = 1'b1;
    cyc();
    n_tests++;
    if (cpu_ce !== 1'b0 || halted !== 1'b1 || mode_state !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_enter: got ce=%b halted=%b ms=%b want 0 1 10", cpu_ce, halted, mode_state);
    end
    for (int i = 0; i < 12; i++) begin
      step_pulse = i[0];
      run_mode   = i[1];
      hlt        = (i < 4);
      cyc();
      if (cpu_ce) ces++;
      n_tests++;
      if ({cpu_ce, cpu_clk_led, halted, mode_state} !== {m_ce, m_led, m_halt, m_ms}) begin
        n_fail++;
        $display("FAIL halt_model[%0d]: got %b%b%b%b want %b%b%b%b", i, cpu_ce, cpu_clk_led, halted, mode_state, m_ce, m_led, m_halt, m_ms);
      end
    end
    n_tests++;
    if (ces !== 0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_frozen: got ces=%0d halted=%b want 0 1", ces, halted);
    end
    step_pulse = 1'b0;
    run_mode   = 1'b0;
    rst        = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if ({cpu_ce, cpu_clk_led, halted, mode_state} !== 5'b00000) begin
      n_fail++;
      $display("FAIL halt_reset: got ce=%b led=%b halted=%b ms=%b want all 0", cpu_ce, cpu_clk_led, halted, mode_state);
    end
  endtask

  task automatic test_mode_switch();
    int ces = 0;
    div_value = 24'd8;
    run_mode  = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      step_pulse = (i == 1);
      cyc();
      if (cpu_ce) ces++;
    end
    step_pulse = 1'b0;
    run_mode   = 1'b0;
    cyc();
    n_tests++;
    if (ces !== 0 || cpu_ce !== 1'b0 || mode_state !== 2'b00) begin
      n_fail++;
      $display("FAIL run_to_step: got ces=%0d ce=%b ms=%b want 0 0 00", ces, cpu_ce, mode_state);
    end
    cyc();
    step_pulse = 1'b1;
    ces = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (cpu_ce) ces++;
    end
    step_pulse = 1'b0;
    n_tests++;
    if (ces !== 1) begin
      n_fail++;
      $display("FAIL step_after_run: got %0d ce want 1", ces);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    div_value = 24'd6;
    run_mode  = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if ({cpu_ce, cpu_clk_led, halted, mode_state} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid: got ce=%b led=%b halted=%b ms=%b want all 0", cpu_ce, cpu_clk_led, halted, mode_state);
    end
    cyc();
    for (int k = 1; k <= 10 && first < 0; k++) begin
      cyc();
      if (cpu_ce) first = k;
    end
    n_tests++;
    if (first !== 6) begin
      n_fail++;
      $display("FAIL reset_reentry: first ce at %0d want 6", first);
    end
    run_mode = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      hlt        = ($urandom_range(0, 149) == 0);
      step_pulse = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 9) == 0) div_value = 24'($urandom_range(0, 7));
      cyc();
      n_tests++;
      if ({cpu_ce, cpu_clk_led, halted, mode_state} !== {m_ce, m_led, m_halt, m_ms}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b%b%b%b want %b%b%b%b", i, cpu_ce, cpu_clk_led, halted, mode_state, m_ce, m_led, m_halt, m_ms);
      end
    end
    rst = 1'b0;
    hlt = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_step();
    test_run();
    test_div_edges();
    test_halt();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_clock_ctrl.md
Name: sap_clock_ctrl

Overview:
- Downstream consumer of the manual single-step pulse generator. Decides when the SAP-1 core advances.
- Produces a one-cycle clock enable `cpu_ce`, either from the free-running programmable divider (RUN) or from manual step pulses (STEP). Freezes permanently on the CPU's HLT signal.
- The core runs on `clk` and gates its registers with `cpu_ce`. This block never generates a derived clock.

Parameters:
- DIV_WIDTH, 24: width of the divider counter and of `div_value`.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- run_mode  input  1  already synchronised switch level; 1 = free run, 0 = single step.
- step_pulse  input  1  manual step request from the pulser; may be high for more than one cycle.
- div_value  input  DIV_WIDTH  run-mode period in clk cycles; values 0 and 1 both mean "every cycle".
- hlt  input  1  HLT control line from the SAP-1 controller, level.
- cpu_ce  output  1  one-cycle enable that advances the CPU.
- cpu_clk_led  output  1  toggles on every cpu_ce, for the clock LED.
- halted  output  1  high while in HALT.
- mode_state  output  2  current state: 00 STEP, 01 RUN, 10 HALT.

Behaviour:
- Reset, synchronous, checked before everything else, including mid-count and while in HALT:
  - state = STEP, divider count = 0, step edge register = 0.
  - cpu_ce = 0, cpu_clk_led = 0, halted = 0, mode_state = 00.
- All outputs are registered.
- Step edge detect:
  - step_rise = step_pulse & ~step_pulse_q.
  - step_pulse_q samples step_pulse every cycle in all states.
  - A held step_pulse yields exactly one step.
- FSM, evaluated every cycle when rst = 0, in priority order:
  1. hlt = 1 in STEP or RUN -> next state HALT. cpu_ce = 0 that cycle, even if a step or terminal count coincides. Count cleared.
  2. STEP with run_mode = 1 -> RUN. Count cleared; no ce that cycle.
  3. RUN with run_mode = 0 -> STEP. Count cleared; no ce that cycle; a partial period is discarded.
  4. HALT: stays in HALT until rst. run_mode, step_pulse and div_value are ignored; cpu_ce = 0.
- STEP:
  - cpu_ce = 1 in the cycle after a cycle with step_rise = 1 (one-cycle latency).
  - Exactly one ce per rising edge.
- RUN:
  - Effective divisor eff = max(div_value, 1).
  - The count increments each cycle. When count >= eff - 1, the next cycle has cpu_ce = 1 and the count wraps to 0.
  - The `>=` compare makes a div_value decrease mid-count terminate the period on the next cycle; the count never runs away.
  - The first ce after entering RUN arrives eff cycles after the transition cycle. Steady-state ce period is exactly eff cycles.
  - step_rise in RUN is ignored; it is not queued.
- cpu_clk_led: inverts in the same cycle that cpu_ce = 1.
- halted is 1 exactly when mode_state = 10.
- Simultaneous events:
  - hlt beats run_mode change and step.
  - run_mode change beats terminal count: no ce in the cycle the mode changes.
  - rst beats all.

Decomposition:
- Package sap_clk_pkg:
  - state encoding constants ST_STEP = 2'b00, ST_RUN = 2'b01, ST_HALT = 2'b10.
  - DIV_WIDTH default.
- One sub-module, sap_clk_divider:
  - Ports: clk, rst, clear, enable, div_value, tick.
  - Implements the `>=` terminal-count counter with wrap.
- The FSM, edge detect and LED toggle stay in sap_clock_ctrl.

Test Plan:
1. Reset, then STEP mode; step_pulse held high for 5 cycles -> exactly one cpu_ce, 1 cycle after the rising edge; cpu_clk_led goes 0 -> 1; mode_state = 00.
2. run_mode = 1, div_value = 4 -> mode_state = 01; first cpu_ce 4 cycles after the transition, then every 4 cycles; 10 periods give 10 ce and 10 LED toggles.
3. RUN with div_value = 0 and then 1 -> cpu_ce high every cycle in both cases. RUN with div_value = 100 at count 60, change div_value to 10 -> ce on the next cycle, then every 10 cycles.
4. RUN with div_value = 3; assert hlt in the cycle a terminal count would fire -> no ce; halted = 1, mode_state = 10. Further step_pulse, run_mode toggles and hlt release -> still no ce. Then rst -> STEP, halted = 0, cpu_clk_led = 0.
5. RUN with div_value = 8; drop run_mode at count 5 -> no ce, mode_state = 00. A step rising edge 2 cycles later -> single ce. A step_pulse asserted while in RUN -> no ce.
6. rst asserted for 1 cycle mid-period in RUN -> all outputs return to reset values on the next edge; first ce only after a new step_rise, or eff cycles after run_mode is re-entered.
